gbc_cartridge_bridge: RTL and testbench
=======================================

GBC_CARTRIDGE_BRIDGE -- requirements
Module: gbc_cartridge_bridge

Interface
REQ-001 The block SHALL have parameter AddrWidth, default 16, meaning system and GamePak address width.
REQ-002 The block SHALL have parameter DataWidth, default 8, meaning data width of bus, GamePak and mapper.
REQ-003 The block SHALL have parameter PakWaitStates, default 3, range 1-15, meaning enabled cycles from GamePak read strobe to data sample.
REQ-004 The block SHALL have parameter PowerDown, default 1, meaning GamePak outputs are driven only when the cartridge is selected.
REQ-005 The block SHALL have port list: Clk in 1 system clock; Reset in 1 reset, synchronous, active-high; ClkEn in 1 clock enable.
REQ-006 The block SHALL have bus ports: BusAccess in 1; BusWrite in 1; BusAddress in AddrWidth; BusDToTarget in DataWidth; BusDToInitiator out DataWidth; BusReady out 1 (can accept); BusDataReady out 1 (one-cycle read-data pulse).
REQ-007 The block SHALL have mapper ports: MapAccess out 1; MapWrite out 1; MapAddress out AddrWidth; MapDToTarget out DataWidth; MapDToInitiator in DataWidth; MapReady in 1; MapDataReady in 1.
REQ-008 The block SHALL have GamePak ports: PakCS out 1; PakRead out 1; PakWrite out 1; PakAddress out AddrWidth; PakDToPak out DataWidth; PakDFromPak in DataWidth; PakReset out 1.
REQ-009 The block SHALL have status ports: UseCartridge out 1 (physical cart selected); ProbeDone out 1; ForceMapper in 1 (skip probe, select mapper).

Function
REQ-010 The block SHALL advance all state only on Clk edges with ClkEn=1, except Reset.
REQ-011 The block SHALL implement states PROBE_INIT, PROBE_RD, PROBE_WAIT, PROBE_CHECK, IDLE, PAK_RD, PAK_WR, MAP_FWD.
REQ-012 In PROBE_INIT, if ForceMapper=1 the block SHALL set UseCartridge=0, ProbeDone=1 and go to IDLE; otherwise it SHALL clear an 8-bit accumulator, set probe address 0x0134 and go to PROBE_RD.
REQ-013 In PROBE_RD the block SHALL drive PakCS=1, PakRead=1, PakAddress=probe address, load a wait counter with PakWaitStates and go to PROBE_WAIT.
REQ-014 In PROBE_WAIT the block SHALL decrement the counter each enabled cycle and sample PakDFromPak when the counter reaches 0.
REQ-015 For probe addresses 0x0134-0x014C the block SHALL update the accumulator as acc = acc - data - 1, modulo 256, then increment the address and return to PROBE_RD.
REQ-016 At address 0x014D the block SHALL go to PROBE_CHECK, set UseCartridge=1 if the sampled byte equals acc, else 0, then assert ProbeDone=1 and go to IDLE.
REQ-017 BusReady SHALL be 0 in all PROBE_* states and in all states other than IDLE.
REQ-018 In IDLE, BusAccess=1 with UseCartridge=1 SHALL latch address and data and go to PAK_WR if BusWrite=1, else PAK_RD.
REQ-019 PAK_RD SHALL hold PakCS=PakRead=1 for PakWaitStates enabled cycles, register PakDFromPak onto BusDToInitiator, pulse BusDataReady for one enabled cycle, and return to IDLE; read latency SHALL be PakWaitStates+1 enabled cycles from acceptance.
REQ-020 PAK_WR SHALL hold PakCS=PakWrite=1 with PakDToPak=latched data for PakWaitStates enabled cycles, then return to IDLE with no BusDataReady.
REQ-021 In IDLE, BusAccess=1 with UseCartridge=0 SHALL go to MAP_FWD; MapAccess SHALL pulse for one cycle with latched request; the block SHALL wait for MapDataReady on reads, or MapReady on writes, then forward MapDToInitiator and pulse BusDataReady on reads, and return to IDLE.
REQ-022 With PowerDown=1 and UseCartridge=0 after probe, all Pak outputs SHALL be held 0 except PakReset.
REQ-023 PakReset SHALL equal Reset registered by one cycle.
REQ-024 UseCartridge SHALL change only in PROBE_CHECK or PROBE_INIT.
REQ-025 BusAccess arriving while not in IDLE SHALL be ignored; the initiator holds it until BusReady=1.

Reset
REQ-026 On Reset=1 the block SHALL enter PROBE_INIT and clear UseCartridge, ProbeDone, BusReady, BusDataReady, BusDToInitiator, MapAccess, PakCS, PakRead, PakWrite, PakAddress, PakDToPak, and the accumulator and counter, regardless of ClkEn.
REQ-027 Reset asserted mid-probe or mid-access SHALL abort the operation without a BusDataReady pulse and SHALL restart the probe.

Verification
REQ-028 Cart model with valid header (bytes 0x0134-0x014C all 0x00, 0x014D=0xE7) -> ProbeDone=1, UseCartridge=1 after 26 reads.
REQ-029 Same model with 0x014D=0x00 -> UseCartridge=0, Pak outputs 0 after ProbeDone.
REQ-030 ForceMapper=1 at reset release -> ProbeDone=1 within 2 enabled cycles, no PakRead pulses.
REQ-031 Cart mode, PakWaitStates=3, read 0x0100 returning 0x3C -> BusDataReady 4 enabled cycles after acceptance, BusDToInitiator=0x3C.
REQ-032 Mapper mode, write 0x2000=0x05 then read 0x4000 with MapDataReady after 2 cycles -> one MapAccess per request, BusDataReady only on the read.
REQ-033 Reset pulsed during PROBE_WAIT and during PAK_RD, with ClkEn toggling 50% -> no stray BusDataReady, probe restarts at 0x0134.

Source files
------------

// File: rtl/gbc_cartridge_bridge.sv
// GamePak bridge: probes the cartridge header checksum after reset, then
// routes bus accesses either to the physical GamePak (fixed wait-state
// strobes) or to an internal mapper (handshaked forward).
module gbc_cartridge_bridge #(
  parameter int AddrWidth     = 16,
  parameter int DataWidth     = 8,
  parameter int PakWaitStates = 3,
  parameter int PowerDown     = 1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 ClkEn,
  // initiator bus
  input  logic                 BusAccess,
  input  logic                 BusWrite,
  input  logic [AddrWidth-1:0] BusAddress,
  input  logic [DataWidth-1:0] BusDToTarget,
  output logic [DataWidth-1:0] BusDToInitiator,
  output logic                 BusReady,
  output logic                 BusDataReady,
  // mapper
  output logic                 MapAccess,
  output logic                 MapWrite,
  output logic [AddrWidth-1:0] MapAddress,
  output logic [DataWidth-1:0] MapDToTarget,
  input  logic [DataWidth-1:0] MapDToInitiator,
  input  logic                 MapReady,
  input  logic                 MapDataReady,
  // GamePak
  output logic                 PakCS,
  output logic                 PakRead,
  output logic                 PakWrite,
  output logic [AddrWidth-1:0] PakAddress,
  output logic [DataWidth-1:0] PakDToPak,
  input  logic [DataWidth-1:0] PakDFromPak,
  output logic                 PakReset,
  // status
  output logic                 UseCartridge,
  output logic                 ProbeDone,
  input  logic                 ForceMapper
);

  localparam logic [2:0] S_PROBE_INIT  = 3'd0;
  localparam logic [2:0] S_PROBE_RD    = 3'd1;
  localparam logic [2:0] S_PROBE_WAIT  = 3'd2;
  localparam logic [2:0] S_PROBE_CHECK = 3'd3;
  localparam logic [2:0] S_IDLE        = 3'd4;
  localparam logic [2:0] S_PAK_RD      = 3'd5;
  localparam logic [2:0] S_PAK_WR      = 3'd6;
  localparam logic [2:0] S_MAP_FWD     = 3'd7;

  localparam logic [3:0]           WaitLoad   = 4'(PakWaitStates);
  // header bytes 0x0134..0x014C feed the checksum, 0x014D holds it
  localparam logic [AddrWidth-1:0] ProbeFirst = AddrWidth'(16'h0134);
  localparam logic [AddrWidth-1:0] ProbeLast  = AddrWidth'(16'h014D);

  logic [2:0]           state_q, state_d;
  logic [7:0]           acc_q, acc_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [AddrWidth-1:0] probe_addr_q, probe_addr_d;
  logic [7:0]           sample_q, sample_d;
  logic                 use_cart_q, use_cart_d;
  logic                 probe_done_q, probe_done_d;
  logic [DataWidth-1:0] bus_rdata_q, bus_rdata_d;
  logic                 bus_drdy_q, bus_drdy_d;
  logic                 map_acc_q, map_acc_d;
  logic                 map_wr_q, map_wr_d;
  logic [AddrWidth-1:0] map_addr_q, map_addr_d;
  logic [DataWidth-1:0] map_wdata_q, map_wdata_d;
  logic                 pak_cs_q, pak_cs_d;
  logic                 pak_rd_q, pak_rd_d;
  logic                 pak_wr_q, pak_wr_d;
  logic [AddrWidth-1:0] pak_addr_q, pak_addr_d;
  logic [DataWidth-1:0] pak_wdata_q, pak_wdata_d;
  logic                 pak_reset_q;
  logic                 wait_done;
  logic                 pak_off;

  // the wait counter hits zero on this enabled edge
  assign wait_done = (cnt_q == 4'd1);

  // Next-state and datapath decode for the probe / routing FSM
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    probe_addr_d = probe_addr_q;
    sample_d     = sample_q;
    use_cart_d   = use_cart_q;
    probe_done_d = probe_done_q;
    bus_rdata_d  = bus_rdata_q;
    bus_drdy_d   = 1'b0;
    map_acc_d    = 1'b0;
    map_wr_d     = map_wr_q;
    map_addr_d   = map_addr_q;
    map_wdata_d  = map_wdata_q;
    pak_cs_d     = pak_cs_q;
    pak_rd_d     = pak_rd_q;
    pak_wr_d     = pak_wr_q;
    pak_addr_d   = pak_addr_q;
    pak_wdata_d  = pak_wdata_q;
    case (state_q)
      S_PROBE_INIT: begin
        if (ForceMapper) begin
          use_cart_d   = 1'b0;
          probe_done_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
          acc_d        = 8'd0;
          probe_addr_d = ProbeFirst;
          state_d      = S_PROBE_RD;
        end
      end
      S_PROBE_RD: begin
        pak_cs_d   = 1'b1;
        pak_rd_d   = 1'b1;
        pak_addr_d = probe_addr_q;
        cnt_d      = WaitLoad;
        state_d    = S_PROBE_WAIT;
      end
      S_PROBE_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (wait_done) begin
          // drop the strobe between header reads so each byte is a fresh read
          pak_cs_d = 1'b0;
          pak_rd_d = 1'b0;
          if (probe_addr_q == ProbeLast) begin
            sample_d = PakDFromPak[7:0];
            state_d  = S_PROBE_CHECK;
          end else begin
            acc_d        = acc_q - PakDFromPak[7:0] - 8'd1;
            probe_addr_d = probe_addr_q + AddrWidth'(1);
            state_d      = S_PROBE_RD;
          end
        end
      end
      S_PROBE_CHECK: begin
        use_cart_d   = (sample_q == acc_q);
        probe_done_d = 1'b1;
        state_d      = S_IDLE;
      end
      S_IDLE: begin
        if (BusAccess) begin
          if (use_cart_q) begin
            pak_cs_d   = 1'b1;
            pak_addr_d = BusAddress;
            cnt_d      = WaitLoad;
            if (BusWrite) begin
              pak_wr_d    = 1'b1;
              pak_wdata_d = BusDToTarget;
              state_d     = S_PAK_WR;
            end else begin
              pak_rd_d = 1'b1;
              state_d  = S_PAK_RD;
            end
          end else begin
            map_acc_d   = 1'b1;
            map_wr_d    = BusWrite;
            map_addr_d  = BusAddress;
            map_wdata_d = BusDToTarget;
            state_d     = S_MAP_FWD;
          end
        end
      end
      S_PAK_RD: begin
        cnt_d = cnt_q - 4'd1;
        if (wait_done) begin
          bus_rdata_d = PakDFromPak;
          bus_drdy_d  = 1'b1;
          pak_cs_d    = 1'b0;
          pak_rd_d    = 1'b0;
          state_d     = S_IDLE;
        end
      end
      S_PAK_WR: begin
        cnt_d = cnt_q - 4'd1;
        if (wait_done) begin
          pak_cs_d = 1'b0;
          pak_wr_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      S_MAP_FWD: begin
        // writes complete on MapReady, reads on MapDataReady
        if (map_wr_q ? MapReady : MapDataReady) begin
          if (!map_wr_q) begin
            bus_rdata_d = MapDToInitiator;
            bus_drdy_d  = 1'b1;
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_PROBE_INIT;
    endcase
  end

  // Control and pin registers: reset overrides ClkEn, otherwise advance on enable
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= S_PROBE_INIT;
      acc_q        <= 8'd0;
      cnt_q        <= 4'd0;
      use_cart_q   <= 1'b0;
      probe_done_q <= 1'b0;
      bus_rdata_q  <= '0;
      bus_drdy_q   <= 1'b0;
      map_acc_q    <= 1'b0;
      pak_cs_q     <= 1'b0;
      pak_rd_q     <= 1'b0;
      pak_wr_q     <= 1'b0;
      pak_addr_q   <= '0;
      pak_wdata_q  <= '0;
    end else if (ClkEn) begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      use_cart_q   <= use_cart_d;
      probe_done_q <= probe_done_d;
      bus_rdata_q  <= bus_rdata_d;
      bus_drdy_q   <= bus_drdy_d;
      map_acc_q    <= map_acc_d;
      pak_cs_q     <= pak_cs_d;
      pak_rd_q     <= pak_rd_d;
      pak_wr_q     <= pak_wr_d;
      pak_addr_q   <= pak_addr_d;
      pak_wdata_q  <= pak_wdata_d;
    end
  end

  // Data-only registers: always written before being consumed, so no reset
  always_ff @(posedge Clk) begin
    if (ClkEn) begin
      probe_addr_q <= probe_addr_d;
      sample_q     <= sample_d;
      map_wr_q     <= map_wr_d;
      map_addr_q   <= map_addr_d;
      map_wdata_q  <= map_wdata_d;
    end
  end

  // Cartridge reset follows system reset one clock later, independent of ClkEn
  always_ff @(posedge Clk) begin
    pak_reset_q <= Reset;
  end

  // once the probe has rejected the cartridge, park every GamePak pin low
  assign pak_off = (PowerDown != 0) && probe_done_q && !use_cart_q;

  assign BusReady        = (state_q == S_IDLE);
  assign BusDataReady    = bus_drdy_q;
  assign BusDToInitiator = bus_rdata_q;
  assign MapAccess       = map_acc_q;
  assign MapWrite        = map_wr_q;
  assign MapAddress      = map_addr_q;
  assign MapDToTarget    = map_wdata_q;
  assign PakCS           = pak_cs_q & ~pak_off;
  assign PakRead         = pak_rd_q & ~pak_off;
  assign PakWrite        = pak_wr_q & ~pak_off;
  assign PakAddress      = pak_off ? '0 : pak_addr_q;
  assign PakDToPak       = pak_off ? '0 : pak_wdata_q;
  assign PakReset        = pak_reset_q;
  assign UseCartridge    = use_cart_q;
  assign ProbeDone       = probe_done_q;

endmodule

// File: tb/tb_gbc_cartridge_bridge.sv
// Bench for gbc_cartridge_bridge: behavioural GamePak and mapper models,
// directed and randomized scenarios, one task per scenario.
module tb_gbc_cartridge_bridge;

  localparam int WAITS = 3;

  logic        Clk, Reset, ClkEn;
  logic        BusAccess, BusWrite;
  logic [15:0] BusAddress;
  logic [7:0]  BusDToTarget, BusDToInitiator;
  logic        BusReady, BusDataReady;
  logic        MapAccess, MapWrite;
  logic [15:0] MapAddress;
  logic [7:0]  MapDToTarget, MapDToInitiator;
  logic        MapReady, MapDataReady;
  logic        PakCS, PakRead, PakWrite;
  logic [15:0] PakAddress;
  logic [7:0]  PakDToPak, PakDFromPak;
  logic        PakReset, UseCartridge, ProbeDone, ForceMapper;

  gbc_cartridge_bridge #(
    .AddrWidth(16), .DataWidth(8), .PakWaitStates(WAITS), .PowerDown(1)
  ) dut (
    .Clk(Clk), .Reset(Reset), .ClkEn(ClkEn),
    .BusAccess(BusAccess), .BusWrite(BusWrite), .BusAddress(BusAddress),
    .BusDToTarget(BusDToTarget), .BusDToInitiator(BusDToInitiator),
    .BusReady(BusReady), .BusDataReady(BusDataReady),
    .MapAccess(MapAccess), .MapWrite(MapWrite), .MapAddress(MapAddress),
    .MapDToTarget(MapDToTarget), .MapDToInitiator(MapDToInitiator),
    .MapReady(MapReady), .MapDataReady(MapDataReady),
    .PakCS(PakCS), .PakRead(PakRead), .PakWrite(PakWrite),
    .PakAddress(PakAddress), .PakDToPak(PakDToPak), .PakDFromPak(PakDFromPak),
    .PakReset(PakReset), .UseCartridge(UseCartridge), .ProbeDone(ProbeDone),
    .ForceMapper(ForceMapper)
  );

  int errors = 0;
  int checks = 0;

  bit [7:0] cart_mem [65536];
  bit [7:0] exp_cart [65536];
  bit [7:0] map_mem  [65536];
  bit [7:0] exp_map  [65536];

  bit en_rand  = 1'b0;
  bit en_force = 1'b0;

  int pakrd_rises = 0;
  int drdy_rises  = 0;
  int mapacc_rises = 0;
  logic [15:0] rd_addrs[$];
  logic [15:0] last_map_waddr;
  logic [7:0]  last_map_wdata;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // ClkEn changes just after each rising edge and is stable for the next edge
  initial begin
    forever begin
      @(posedge Clk);
      #1;
      ClkEn = en_rand ? 1'($urandom_range(0, 1)) : en_force;
    end
  end

  // GamePak, mapper and activity monitors, evaluated mid-cycle
  initial begin
    bit prev_rd, prev_drdy, prev_ma;
    int dly;
    prev_rd = 0; prev_drdy = 0; prev_ma = 0; dly = 0;
    forever begin
      @(negedge Clk);
      if (PakCS && PakWrite) cart_mem[PakAddress] = PakDToPak;
      PakDFromPak = (PakCS && PakRead) ? cart_mem[PakAddress] : 8'hFF;
      if (PakRead && !prev_rd) begin
        pakrd_rises++;
        rd_addrs.push_back(PakAddress);
      end
      prev_rd = PakRead;
      if (BusDataReady && !prev_drdy) drdy_rises++;
      prev_drdy = BusDataReady;
      if (MapAccess && !prev_ma) mapacc_rises++;
      prev_ma = MapAccess;
      if (ClkEn) begin
        if (dly > 0) begin
          dly--;
          MapDataReady = (dly == 0);
        end else begin
          MapDataReady = 1'b0;
        end
        if (MapAccess) begin
          if (MapWrite) begin
            map_mem[MapAddress] = MapDToTarget;
            last_map_waddr = MapAddress;
            last_map_wdata = MapDToTarget;
          end else begin
            MapDToInitiator = map_mem[MapAddress];
            dly = 2;
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge Clk);
    #1;
  endtask

  function automatic bit [7:0] hdr_chk();
    int sum;
    sum = 0;
    for (int a = 'h134; a <= 'h14C; a++) sum += int'(exp_cart[a]);
    return 8'(0 - sum - 25);
  endfunction

  task automatic load_header(input bit zeros, input bit good);
    bit [7:0] b;
    for (int a = 'h134; a <= 'h14C; a++) begin
      b = zeros ? 8'h00 : 8'($urandom);
      cart_mem[a] = b;
      exp_cart[a] = b;
    end
    b = good ? hdr_chk() : (zeros ? 8'h00 : 8'($urandom));
    cart_mem['h14D] = b;
    exp_cart['h14D] = b;
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
  endtask

  task automatic wait_probe(output bit timeout);
    int n;
    n = 0;
    timeout = 1'b0;
    while (!ProbeDone) begin
      step();
      n++;
      if (n > 3000) begin
        timeout = 1'b1;
        return;
      end
    end
  endtask

  // one bus transaction; lat counts enabled cycles from acceptance to BusDataReady
  task automatic bus_access(input bit wr, input logic [15:0] addr, input logic [7:0] wdata,
                            output bit got_drdy, output logic [7:0] rdata,
                            output int lat, output bit timeout);
    int n, budget;
    bit en_cur;
    got_drdy = 0; rdata = '0; lat = 0; timeout = 0; budget = 0;
    while (!BusReady) begin
      step(); budget++;
      if (budget > 200) begin timeout = 1; return; end
    end
    BusAccess = 1'b1; BusWrite = wr; BusAddress = addr; BusDToTarget = wdata;
    while (!ClkEn) begin
      step(); budget++;
      if (budget > 200) begin timeout = 1; BusAccess = 1'b0; return; end
    end
    step();
    BusAccess = 1'b0;
    n = 1;
    while (1) begin
      if (BusDataReady) begin
        got_drdy = 1; rdata = BusDToInitiator; lat = n;
        return;
      end
      if (wr && BusReady) return;
      en_cur = ClkEn;
      step(); budget++;
      if (en_cur) n++;
      if (budget > 200) begin timeout = 1; return; end
    end
  endtask

  task automatic test_reset();
    en_rand = 0; en_force = 0;
    Reset = 1'b1;
    repeat (3) step();
    checks++;
    if ({UseCartridge, ProbeDone, BusReady, BusDataReady, MapAccess, PakCS, PakRead, PakWrite} !== 8'h00) begin
      errors++;
      $display("FAIL reset_flags: got %b required 00000000",
               {UseCartridge, ProbeDone, BusReady, BusDataReady, MapAccess, PakCS, PakRead, PakWrite});
    end
    checks++;
    if ({BusDToInitiator, PakAddress, PakDToPak} !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got %h required 0", {BusDToInitiator, PakAddress, PakDToPak});
    end
    checks++;
    if (PakReset !== 1'b1) begin
      errors++;
      $display("FAIL reset_pakreset_high: got %b required 1", PakReset);
    end
    Reset = 1'b0;
    repeat (6) step();
    checks++;
    if ({ProbeDone, PakRead, PakReset} !== 3'b000) begin
      errors++;
      $display("FAIL clken_low_hold: got %b required 000", {ProbeDone, PakRead, PakReset});
    end
  endtask

  task automatic test_force_mapper();
    int p0, n;
    bit en_cur;
    p0 = pakrd_rises;
    ForceMapper = 1'b1; en_rand = 0; en_force = 1;
    Reset = 1'b1; step(); step(); Reset = 1'b0;
    n = 0;
    while (!ProbeDone && n < 20) begin
      en_cur = ClkEn; step();
      if (en_cur) n++;
    end
    checks++;
    if (n > 2) begin
      errors++;
      $display("FAIL force_probe_time: got %0d enabled cycles required <= 2", n);
    end
    checks++;
    if ({UseCartridge, BusReady} !== 2'b01) begin
      errors++;
      $display("FAIL force_mode: got UseCartridge/BusReady %b required 01", {UseCartridge, BusReady});
    end
    step(); step();
    checks++;
    if (pakrd_rises !== p0) begin
      errors++;
      $display("FAIL force_no_pakread: got %0d reads required 0", pakrd_rises - p0);
    end
    ForceMapper = 1'b0;
  endtask

  task automatic test_mapper();
    int m0, d0, lat;
    bit got, to;
    logic [7:0] rd, wd;
    logic [15:0] a;
    m0 = mapacc_rises; d0 = drdy_rises;
    bus_access(1'b1, 16'h2000, 8'h05, got, rd, lat, to);
    step();
    checks++;
    if (to || got || mapacc_rises !== m0 + 1) begin
      errors++;
      $display("FAIL map_write: got timeout=%0b drdy=%0b accesses=%0d required 0 0 1", to, got, mapacc_rises - m0);
    end
    exp_map[16'h2000] = 8'h05;
    checks++;
    if ({last_map_waddr, last_map_wdata} !== {16'h2000, 8'h05}) begin
      errors++;
      $display("FAIL map_write_data: got %h/%h required 2000/05", last_map_waddr, last_map_wdata);
    end
    wd = 8'($urandom);
    map_mem[16'h4000] = wd; exp_map[16'h4000] = wd;
    bus_access(1'b0, 16'h4000, 8'h00, got, rd, lat, to);
    checks++;
    if (to || !got || rd !== exp_map[16'h4000]) begin
      errors++;
      $display("FAIL map_read: got timeout=%0b drdy=%0b data=%h required 0 1 %h", to, got, rd, exp_map[16'h4000]);
    end
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL map_read_latency: got %0d required 4", lat);
    end
    step(); step();
    checks++;
    if (mapacc_rises !== m0 + 2 || drdy_rises !== d0 + 1) begin
      errors++;
      $display("FAIL map_counts: got accesses=%0d drdy=%0d required 2 1", mapacc_rises - m0, drdy_rises - d0);
    end
    en_rand = 1;
    for (int i = 0; i < 10; i++) begin
      a = 16'($urandom_range(16'h2000, 16'h20FF));
      if ($urandom_range(0, 1) == 1) begin
        wd = 8'($urandom);
        exp_map[a] = wd;
        bus_access(1'b1, a, wd, got, rd, lat, to);
        checks++;
        if (to || got) begin
          errors++;
          $display("FAIL map_rand_write: got timeout=%0b drdy=%0b required 0 0", to, got);
        end
      end else begin
        bus_access(1'b0, a, 8'h00, got, rd, lat, to);
        checks++;
        if (to || !got || rd !== exp_map[a]) begin
          errors++;
          $display("FAIL map_rand_read: addr %h got %h drdy=%0b required %h", a, rd, got, exp_map[a]);
        end
      end
    end
    checks++;
    if ({PakCS, PakRead, PakWrite, PakAddress, PakDToPak} !== 27'h0) begin
      errors++;
      $display("FAIL map_pak_idle: got %h required 0", {PakCS, PakRead, PakWrite, PakAddress, PakDToPak});
    end
  endtask

  task automatic test_probe_invalid();
    int p0;
    bit to;
    en_rand = 1;
    load_header(1'b1, 1'b0);
    p0 = pakrd_rises;
    pulse_reset();
    wait_probe(to);
    step();
    checks++;
    if (to || UseCartridge !== 1'b0 || pakrd_rises - p0 !== 26) begin
      errors++;
      $display("FAIL probe_invalid: got timeout=%0b use=%b reads=%0d required 0 0 26", to, UseCartridge, pakrd_rises - p0);
    end
    checks++;
    if ({PakCS, PakRead, PakWrite, PakAddress, PakDToPak} !== 27'h0) begin
      errors++;
      $display("FAIL powerdown_pins: got %h required 0", {PakCS, PakRead, PakWrite, PakAddress, PakDToPak});
    end
  endtask

  task automatic test_probe_valid();
    bit to, seq_ok;
    en_rand = 0; en_force = 1;
    load_header(1'b1, 1'b1);
    rd_addrs.delete();
    pulse_reset();
    wait_probe(to);
    checks++;
    if (to || UseCartridge !== 1'b1 || rd_addrs.size() !== 26) begin
      errors++;
      $display("FAIL probe_valid: got timeout=%0b use=%b reads=%0d required 0 1 26", to, UseCartridge, rd_addrs.size());
    end
    seq_ok = (rd_addrs.size() == 26);
    for (int i = 0; i < rd_addrs.size(); i++)
      if (rd_addrs[i] !== 16'(16'h0134 + i)) seq_ok = 0;
    checks++;
    if (!seq_ok) begin
      errors++;
      $display("FAIL probe_sequence: got first %h count %0d required 0134..014D",
               (rd_addrs.size() > 0) ? rd_addrs[0] : 16'hxxxx, rd_addrs.size());
    end
  endtask

  task automatic test_cart_read();
    int m0, lat;
    bit got, to;
    logic [7:0] rd;
    cart_mem[16'h0100] = 8'h3C; exp_cart[16'h0100] = 8'h3C;
    m0 = mapacc_rises;
    bus_access(1'b0, 16'h0100, 8'h00, got, rd, lat, to);
    checks++;
    if (to || !got || rd !== 8'h3C) begin
      errors++;
      $display("FAIL cart_read_data: got timeout=%0b drdy=%0b data=%h required 0 1 3c", to, got, rd);
    end
    checks++;
    if (lat !== WAITS + 1) begin
      errors++;
      $display("FAIL cart_read_latency: got %0d required %0d", lat, WAITS + 1);
    end
    checks++;
    if (mapacc_rises !== m0) begin
      errors++;
      $display("FAIL cart_no_mapper: got %0d mapper accesses required 0", mapacc_rises - m0);
    end
  endtask

  task automatic test_cart_random();
    int lat;
    bit got, to;
    logic [7:0] rd, wd;
    logic [15:0] a;
    en_rand = 1;
    for (int i = 0; i < 14; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        a = 16'($urandom_range(16'hC000, 16'hC00F));
        wd = 8'($urandom);
        exp_cart[a] = wd;
        bus_access(1'b1, a, wd, got, rd, lat, to);
        step();
        checks++;
        if (to || got || cart_mem[a] !== wd) begin
          errors++;
          $display("FAIL cart_write: addr %h got pak=%h drdy=%0b required %h 0", a, cart_mem[a], got, wd);
        end
      end else begin
        a = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(16'hC000, 16'hC00F))
                                        : 16'($urandom_range(16'h0000, 16'h7FFF));
        bus_access(1'b0, a, 8'h00, got, rd, lat, to);
        checks++;
        if (to || !got || rd !== exp_cart[a] || lat !== WAITS + 1) begin
          errors++;
          $display("FAIL cart_rand_read: addr %h got %h lat %0d required %h lat %0d", a, rd, lat, exp_cart[a], WAITS + 1);
        end
      end
    end
  endtask

  task automatic test_probe_random();
    bit to, expect_use;
    en_rand = 1;
    for (int i = 0; i < 4; i++) begin
      load_header(1'b0, 1'($urandom_range(0, 1)));
      expect_use = (exp_cart['h14D] == hdr_chk());
      pulse_reset();
      wait_probe(to);
      checks++;
      if (to || UseCartridge !== expect_use) begin
        errors++;
        $display("FAIL probe_random_%0d: got timeout=%0b use=%b required 0 %b", i, to, UseCartridge, expect_use);
      end
    end
  endtask

  task automatic test_reset_abort();
    int d0, n;
    bit to;
    en_rand = 1;
    load_header(1'b1, 1'b1);
    rd_addrs.delete();
    pulse_reset();
    n = 0;
    while ((rd_addrs.size() < 3 || !PakRead) && n < 1000) begin step(); n++; end
    d0 = drdy_rises;
    rd_addrs.delete();
    Reset = 1'b1;
    step();
    checks++;
    if (PakReset !== 1'b1 || PakRead !== 1'b0) begin
      errors++;
      $display("FAIL abort_probe_reset: got PakReset=%b PakRead=%b required 1 0", PakReset, PakRead);
    end
    Reset = 1'b0;
    wait_probe(to);
    checks++;
    if (to || rd_addrs.size() == 0 || rd_addrs[0] !== 16'h0134 || UseCartridge !== 1'b1) begin
      errors++;
      $display("FAIL abort_probe_restart: got timeout=%0b first=%h use=%b required 0 0134 1",
               to, (rd_addrs.size() > 0) ? rd_addrs[0] : 16'hxxxx, UseCartridge);
    end
    BusAccess = 1'b1; BusWrite = 1'b0; BusAddress = 16'h0150;
    n = 0;
    while (!(BusReady && ClkEn) && n < 100) begin step(); n++; end
    step();
    BusAccess = 1'b0;
    checks++;
    if (PakRead !== 1'b1) begin
      errors++;
      $display("FAIL abort_in_pak_rd: got PakRead=%b required 1", PakRead);
    end
    rd_addrs.delete();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    repeat (20) step();
    checks++;
    if (drdy_rises !== d0 || BusDataReady !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_drdy: got %0d stray pulses required 0", drdy_rises - d0);
    end
    wait_probe(to);
    checks++;
    if (to || rd_addrs.size() !== 26 || rd_addrs[0] !== 16'h0134) begin
      errors++;
      $display("FAIL abort_read_restart: got timeout=%0b reads=%0d required 0 26 from 0134", to, rd_addrs.size());
    end
  endtask

  initial begin
    Reset = 1'b1; ClkEn = 1'b0; ForceMapper = 1'b0;
    BusAccess = 1'b0; BusWrite = 1'b0; BusAddress = '0; BusDToTarget = '0;
    MapReady = 1'b1; MapDataReady = 1'b0; MapDToInitiator = '0; PakDFromPak = 8'hFF;
    last_map_waddr = '0; last_map_wdata = '0;
    for (int a = 0; a < 65536; a++) begin
      cart_mem[a] = 8'($urandom);
      exp_cart[a] = cart_mem[a];
      map_mem[a]  = 8'($urandom);
      exp_map[a]  = map_mem[a];
    end
    test_reset();
    test_force_mapper();
    test_mapper();
    test_probe_invalid();
    test_probe_valid();
    test_cart_read();
    test_cart_random();
    test_probe_random();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
